// File: rtl/ahb_dec_pkg.sv
// ahb_dec_pkg: shared encodings and sizing for the AHB address decoder.
package ahb_dec_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        HRESP_OKAY  = 2'b00,
        HRESP_ERROR = 2'b01
    } hresp_e;

    localparam int NUM_SLV = 4;
    localparam int DEF_IDX = 4;

    // One-hot data-phase select pointing at the default slave.
    localparam logic [NUM_SLV:0] DSEL_DEF = 5'b1_0000;

    // True when a data-phase select vector holds exactly one set bit.
    function automatic logic dsel_onehot(input logic [NUM_SLV:0] sel);
        return $onehot(sel);
    endfunction

endpackage

// File: rtl/ahb_dec_region_match.sv
// ahb_dec_region_match: masked compare of an address against one region base.
module ahb_dec_region_match (
    input  logic [31:0] addr,
    input  logic [31:0] base,
    input  logic [31:0] mask,
    output logic        match
);

    assign match = ((addr & mask) == base);

endmodule

// File: rtl/ahb_addr_decoder.sv
// ahb_addr_decoder: AHB address-phase slave select plus data-phase response mux
// for four regions and an external default slave.
// Optional feature: define AHB_DEC_ERRCNT_EN to build the saturating counter of
// accepted default-slave transfers on ERRCNT; otherwise ERRCNT is tied to zero.
module ahb_addr_decoder
    import ahb_dec_pkg::*;
#(
    parameter logic [31:0] BASE0 = 32'h0000_0000,
    parameter logic [31:0] BASE1 = 32'h2000_0000,
    parameter logic [31:0] BASE2 = 32'h4000_0000,
    parameter logic [31:0] BASE3 = 32'h6000_0000,
    parameter logic [31:0] MASK0 = 32'hE000_0000,
    parameter logic [31:0] MASK1 = 32'hE000_0000,
    parameter logic [31:0] MASK2 = 32'hE000_0000,
    parameter logic [31:0] MASK3 = 32'hE000_0000
) (
    input  logic         HCLK,
    input  logic         HRESET,
    input  logic         HSELM,
    input  logic [31:0]  HADDR,
    input  logic [1:0]   HTRANS,
    output logic [3:0]   HSEL_S,
    output logic         HSEL_DEF,
    input  logic [3:0]   HREADYOUT_S,
    input  logic [7:0]   HRESP_S,
    input  logic [127:0] HRDATA_S,
    input  logic         HREADYOUT_DEF,
    input  logic [1:0]   HRESP_DEF,
    output logic         HREADY,
    output logic [1:0]   HRESP,
    output logic [31:0]  HRDATA,
    input  logic         ERRCNT_CLR,
    output logic [15:0]  ERRCNT
);

    localparam logic [31:0] BASE_A [NUM_SLV] = '{BASE0, BASE1, BASE2, BASE3};
    localparam logic [31:0] MASK_A [NUM_SLV] = '{MASK0, MASK1, MASK2, MASK3};

    logic [NUM_SLV-1:0] match;
    logic [NUM_SLV-1:0] hsel_pri;
    logic               any_match;
    logic [NUM_SLV:0]   dsel_p1;

    for (genvar n = 0; n < NUM_SLV; n++) begin : g_region
        ahb_dec_region_match u_match (
            .addr  (HADDR),
            .base  (BASE_A[n]),
            .mask  (MASK_A[n]),
            .match (match[n])
        );
    end

    // Priority resolve: the lowest-index matching region wins an overlap.
    always_comb begin
        hsel_pri  = '0;
        any_match = 1'b0;
        for (int n = 0; n < NUM_SLV; n++) begin
            if (match[n] && !any_match) begin
                hsel_pri[n] = 1'b1;
                any_match   = 1'b1;
            end
        end
    end

    assign HSEL_S   = HSELM ? hsel_pri : '0;
    assign HSEL_DEF = HSELM & ~any_match;

    // ---- address phase -> data phase ----
    // Data-phase owner advances only when the current transfer completes.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dsel_p1 <= DSEL_DEF;
        end else if (HREADY) begin
            dsel_p1 <= HSELM ? {HSEL_DEF, HSEL_S} : DSEL_DEF;
        end
    end

    // Response mux; anything other than a legal slave one-hot falls back to the default slave.
    always_comb begin
        HREADY = HREADYOUT_DEF;
        HRESP  = HRESP_DEF;
        HRDATA = 32'h0;
        if (dsel_onehot(dsel_p1)) begin
            for (int n = 0; n < NUM_SLV; n++) begin
                if (dsel_p1[n]) begin
                    HREADY = HREADYOUT_S[n];
                    HRESP  = HRESP_S[2*n +: 2];
                    HRDATA = HRDATA_S[32*n +: 32];
                end
            end
        end
    end

`ifdef AHB_DEC_ERRCNT_EN
    logic [15:0] errcnt_r;
    logic        unused_ok;

    assign unused_ok = HTRANS[0];

    // Count accepted NONSEQ/SEQ transfers routed to the default slave; clear wins, saturates.
    always_ff @(posedge HCLK) begin
        if (HRESET || ERRCNT_CLR) begin
            errcnt_r <= 16'h0;
        end else if (HSEL_DEF && HTRANS[1] && HREADY && (errcnt_r != 16'hFFFF)) begin
            errcnt_r <= errcnt_r + 16'd1;
        end
    end

    assign ERRCNT = errcnt_r;
`else
    logic unused_ok;

    assign unused_ok = ^{ERRCNT_CLR, HTRANS};
    assign ERRCNT    = 16'h0;
`endif

endmodule

// File: tb/tb_ahb_addr_decoder.sv
// tb_ahb_addr_decoder: directed vectors for the AHB address decoder.
module tb_ahb_addr_decoder;
    import ahb_dec_pkg::*;

`ifdef AHB_DEC_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic         HCLK;
    logic         HRESET;
    logic         HSELM;
    logic [31:0]  HADDR;
    logic [1:0]   HTRANS;
    logic [3:0]   HSEL_S;
    logic         HSEL_DEF;
    logic [3:0]   HREADYOUT_S;
    logic [7:0]   HRESP_S;
    logic [127:0] HRDATA_S;
    logic         HREADYOUT_DEF;
    logic [1:0]   HRESP_DEF;
    logic         HREADY;
    logic [1:0]   HRESP;
    logic [31:0]  HRDATA;
    logic         ERRCNT_CLR;
    logic [15:0]  ERRCNT;

    // Overlap instance outputs
    logic [3:0]   hsel_s_ov;
    logic         hsel_def_ov;
    logic         hready_ov;
    logic [1:0]   hresp_ov;
    logic [31:0]  hrdata_ov;
    logic [15:0]  errcnt_ov;

    int n_chk  = 0;
    int n_fail = 0;

    ahb_addr_decoder u_dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .HSELM         (HSELM),
        .HADDR         (HADDR),
        .HTRANS        (HTRANS),
        .HSEL_S        (HSEL_S),
        .HSEL_DEF      (HSEL_DEF),
        .HREADYOUT_S   (HREADYOUT_S),
        .HRESP_S       (HRESP_S),
        .HRDATA_S      (HRDATA_S),
        .HREADYOUT_DEF (HREADYOUT_DEF),
        .HRESP_DEF     (HRESP_DEF),
        .HREADY        (HREADY),
        .HRESP         (HRESP),
        .HRDATA        (HRDATA),
        .ERRCNT_CLR    (ERRCNT_CLR),
        .ERRCNT        (ERRCNT)
    );

    ahb_addr_decoder #(
        .BASE1 (32'h0000_0000),
        .MASK1 (32'h0000_0000)
    ) u_dut_ov (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .HSELM         (HSELM),
        .HADDR         (HADDR),
        .HTRANS        (HTRANS),
        .HSEL_S        (hsel_s_ov),
        .HSEL_DEF      (hsel_def_ov),
        .HREADYOUT_S   (HREADYOUT_S),
        .HRESP_S       (HRESP_S),
        .HRDATA_S      (HRDATA_S),
        .HREADYOUT_DEF (HREADYOUT_DEF),
        .HRESP_DEF     (HRESP_DEF),
        .HREADY        (hready_ov),
        .HRESP         (hresp_ov),
        .HRDATA        (hrdata_ov),
        .ERRCNT_CLR    (ERRCNT_CLR),
        .ERRCNT        (errcnt_ov)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic mid();
        @(negedge HCLK);
    endtask

    initial begin
        HRESET        = 1'b1;
        HSELM         = 1'b0;
        HADDR         = 32'h0;
        HTRANS        = HTRANS_IDLE;
        HREADYOUT_S   = 4'hF;
        HRESP_S       = 8'h0;
        HRDATA_S      = {32'h3333_3333, 32'h2222_2222, 32'hCAFE_F00D, 32'h1111_0000};
        HREADYOUT_DEF = 1'b1;
        HRESP_DEF     = HRESP_OKAY;
        ERRCNT_CLR    = 1'b0;

        // Reset then idle
        tick();
        HRESET = 1'b0;
        mid();
        chk("rst_hready", 32'(HREADY), 32'd1);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_hresp", 32'(HRESP), 32'd0);
        chk("rst_errcnt", 32'(ERRCNT), 32'd0);
        chk("rst_sel", 32'({HSEL_DEF, HSEL_S}), 32'd0);
        HREADYOUT_DEF = 1'b0;
        HRESP_DEF     = HRESP_ERROR;
        #1;
        chk("rst_hready_follow", 32'(HREADY), 32'd0);
        chk("rst_hresp_follow", 32'(HRESP), 32'd1);
        HREADYOUT_DEF = 1'b1;
        HRESP_DEF     = HRESP_OKAY;

        // NONSEQ read to slave 1 with one wait state
        tick();
        HSELM = 1'b1; HADDR = 32'h2000_0010; HTRANS = HTRANS_NONSEQ;
        mid();
        chk("s1_hsel_s", 32'(HSEL_S), 32'h2);
        chk("s1_hsel_def", 32'(HSEL_DEF), 32'd0);
        tick();
        HSELM = 1'b0; HTRANS = HTRANS_IDLE; HREADYOUT_S[1] = 1'b0;
        mid();
        chk("s1_wait_hready", 32'(HREADY), 32'd0);
        tick();
        HREADYOUT_S[1] = 1'b1;
        mid();
        chk("s1_done_hready", 32'(HREADY), 32'd1);
        chk("s1_hrdata", HRDATA, 32'hCAFE_F00D);
        tick();
        mid();
        chk("s1_after_hrdata", HRDATA, 32'h0);

        // Unmapped NONSEQ -> default slave, two-cycle ERROR
        tick();
        HSELM = 1'b1; HADDR = 32'hA000_0000; HTRANS = HTRANS_NONSEQ;
        mid();
        chk("def_hsel_def", 32'(HSEL_DEF), 32'd1);
        chk("def_hsel_s", 32'(HSEL_S), 32'd0);
        tick();
        HSELM = 1'b0; HTRANS = HTRANS_IDLE; HREADYOUT_DEF = 1'b0; HRESP_DEF = HRESP_ERROR;
        mid();
        chk("err1_hresp", 32'(HRESP), 32'd1);
        chk("err1_hready", 32'(HREADY), 32'd0);
        tick();
        HREADYOUT_DEF = 1'b1;
        mid();
        chk("err2_hresp", 32'(HRESP), 32'd1);
        chk("err2_hready", 32'(HREADY), 32'd1);
        chk("err_errcnt", 32'(ERRCNT), CNT_EN ? 32'd1 : 32'd0);
        tick();
        HRESP_DEF = HRESP_OKAY;

        // Decode ignores HTRANS; only NONSEQ/SEQ count
        HSELM = 1'b1; HADDR = 32'h4000_0000; HTRANS = HTRANS_IDLE;
        mid();
        chk("idle_hsel_s", 32'(HSEL_S), 32'h4);
        tick();
        HADDR = 32'hA000_0000; HTRANS = HTRANS_IDLE;
        mid();
        chk("idle_hsel_def", 32'(HSEL_DEF), 32'd1);
        tick();
        HTRANS = HTRANS_BUSY;
        mid();
        chk("idle_nocount", 32'(ERRCNT), CNT_EN ? 32'd1 : 32'd0);
        tick();
        HTRANS = HTRANS_SEQ;
        mid();
        chk("busy_nocount", 32'(ERRCNT), CNT_EN ? 32'd1 : 32'd0);
        tick();
        HSELM = 1'b0; HTRANS = HTRANS_IDLE;
        mid();
        chk("seq_count", 32'(ERRCNT), CNT_EN ? 32'd2 : 32'd0);

        // Decode corners and overlap
        tick();
        HSELM = 1'b1; HADDR = 32'h6000_0000;
        mid();
        chk("dec_s3", 32'({HSEL_DEF, HSEL_S}), 32'h08);
        tick();
        HADDR = 32'h0000_0004;
        mid();
        chk("dec_s0", 32'({HSEL_DEF, HSEL_S}), 32'h01);
        chk("ovl_s0_wins", 32'(hsel_s_ov), 32'h1);
        tick();
        HADDR = 32'hA000_0000;
        mid();
        chk("ovl_catchall", 32'({hsel_def_ov, hsel_s_ov}), 32'h02);
        tick();
        HADDR = 32'hE000_0000;
        mid();
        chk("dec_top_def", 32'({HSEL_DEF, HSEL_S}), 32'h10);
        tick();
        HSELM = 1'b0; HADDR = 32'h2000_0000;
        mid();
        chk("dec_nosel", 32'({HSEL_DEF, HSEL_S, hsel_def_ov, hsel_s_ov}), 32'h0);

        // Reset in the middle of a stalled data phase
        tick();
        HSELM = 1'b1; HADDR = 32'h2000_0000; HTRANS = HTRANS_NONSEQ;
        tick();
        HSELM = 1'b0; HTRANS = HTRANS_IDLE; HREADYOUT_S[1] = 1'b0; HRESET = 1'b1;
        mid();
        chk("midrst_stall", 32'(HREADY), 32'd0);
        tick();
        HRESET = 1'b0;
        mid();
        chk("midrst_hready", 32'(HREADY), 32'd1);
        chk("midrst_hrdata", HRDATA, 32'h0);
        chk("midrst_errcnt", 32'(ERRCNT), 32'd0);

        // Pipelined slave2 -> slave3, slave2 stalls three cycles
        tick();
        HREADYOUT_S[1] = 1'b1;
        HSELM = 1'b1; HADDR = 32'h4000_0000; HTRANS = HTRANS_NONSEQ;
        mid();
        chk("pipe_a_sel", 32'(HSEL_S), 32'h4);
        tick();
        HADDR = 32'h6000_0000; HREADYOUT_S[2] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            mid();
            chk("pipe_stall_sel", 32'(HSEL_S), 32'h8);
            chk("pipe_stall_hready", 32'(HREADY), 32'd0);
            chk("pipe_stall_hrdata", HRDATA, 32'h2222_2222);
            if (k < 2) tick();
        end
        tick();
        HREADYOUT_S[2] = 1'b0;
        HREADYOUT_S[2] = 1'b1; HREADYOUT_S[3] = 1'b0;
        mid();
        chk("pipe_s2_done", 32'(HREADY), 32'd1);
        chk("pipe_s2_hrdata", HRDATA, 32'h2222_2222);
        tick();
        HSELM = 1'b0; HTRANS = HTRANS_IDLE;
        mid();
        chk("pipe_s3_hrdata", HRDATA, 32'h3333_3333);
        chk("pipe_s3_wait", 32'(HREADY), 32'd0);
        tick();
        HREADYOUT_S[3] = 1'b1;
        mid();
        chk("pipe_s3_done", 32'(HREADY), 32'd1);
        chk("pipe_s3_hrdata2", HRDATA, 32'h3333_3333);
        tick();
        mid();
        chk("pipe_back_def", HRDATA, 32'h0);

        // Error counter: clear, count, saturate, clear-over-hit
        tick();
        ERRCNT_CLR = 1'b1;
        tick();
        ERRCNT_CLR = 1'b0;
        mid();
        chk("cnt_clr", 32'(ERRCNT), 32'd0);
        HSELM = 1'b1; HADDR = 32'hA000_0000; HTRANS = HTRANS_NONSEQ;
        repeat (300) tick();
        mid();
        chk("cnt_300", 32'(ERRCNT), CNT_EN ? 32'd300 : 32'd0);
        chk("cnt_hready", 32'(HREADY), 32'd1);
        repeat (65235) tick();
        mid();
        chk("cnt_full", 32'(ERRCNT), CNT_EN ? 32'hFFFF : 32'd0);
        repeat (5) tick();
        mid();
        chk("cnt_sat", 32'(ERRCNT), CNT_EN ? 32'hFFFF : 32'd0);
        ERRCNT_CLR = 1'b1;
        tick();
        ERRCNT_CLR = 1'b0; HSELM = 1'b0; HTRANS = HTRANS_IDLE;
        mid();
        chk("cnt_clr_prio", 32'(ERRCNT), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ahb_addr_decoder.md
AHB_ADDR_DECODER -- requirements
Module: ahb_addr_decoder

Interface
REQ-001 Parameter BASE0..BASE3, default 32'h0000_0000/32'h2000_0000/32'h4000_0000/32'h6000_0000, region base address per slave port.
REQ-002 Parameter MASK0..MASK3, default 32'hE000_0000 each, compare mask per region; HADDR matches region n when (HADDR & MASKn) == BASEn.
REQ-003 HCLK  in  1  clock for all sequential logic.
REQ-004 HRESET  in  1  reset; synchronous and active-high.
REQ-005 HSELM  in  1  master-side select from bus matrix output stage.
REQ-006 HADDR  in  32  address-phase address.
REQ-007 HTRANS  in  2  address-phase transfer type.
REQ-008 HSEL_S  out  4  address-phase select, one bit per slave port.
REQ-009 HSEL_DEF  out  1  address-phase select to the default slave.
REQ-010 HREADYOUT_S  in  4  per-slave ready, bit n from slave n.
REQ-011 HRESP_S  in  8  per-slave response, bits [2n+1:2n] from slave n.
REQ-012 HRDATA_S  in  128  per-slave read data, bits [32n+31:32n] from slave n.
REQ-013 HREADYOUT_DEF  in  1  default slave ready.
REQ-014 HRESP_DEF  in  2  default slave response.
REQ-015 HREADY  out  1  muxed ready, also fed back as HREADY to all slaves.
REQ-016 HRESP  out  2  muxed response.
REQ-017 HRDATA  out  32  muxed read data.
REQ-018 ERRCNT_CLR  in  1  clears error counter (REQ-030).
REQ-019 ERRCNT  out  16  default-slave transfer count.

Function
REQ-020 Address decode is combinational: HSEL_S[n] = HSELM & match(n) & no match on any lower index (lowest index wins overlaps).
REQ-021 HSEL_DEF = HSELM & no region match; exactly one of HSEL_S/HSEL_DEF is high whenever HSELM=1, none when HSELM=0.
REQ-022 Decode is independent of HTRANS; IDLE/BUSY still assert a select.
REQ-023 A 5-bit one-hot data-phase register dsel (bits 0..3 slaves, bit 4 default) loads {HSEL_DEF,HSEL_S} on rising HCLK when HREADY=1; holds when HREADY=0.
REQ-024 If HSELM=0 when HREADY=1, dsel loads 5'b1_0000 (default slave).
REQ-025 HREADY/HRESP/HRDATA are combinational muxes of the source selected by dsel; no added latency; default source gives HRDATA=32'h0.
REQ-026 Wait states (HREADYOUT=0 from selected source) stall dsel; two-cycle ERROR response passes through unmodified.
REQ-027 dsel is never all-zero or multi-hot; any illegal value is treated as default-slave selection.

Reset
REQ-028 On HRESET=1 at rising HCLK: dsel=5'b1_0000, ERRCNT=0.
REQ-029 Reset mid-transfer abandons the data phase; first post-reset cycle outputs follow the default slave (HREADY=HREADYOUT_DEF).

Configuration
REQ-030 With AHB_DEC_ERRCNT_EN defined: ERRCNT increments by 1 per cycle where HSEL_DEF=1 & HTRANS[1]=1 & HREADY=1, saturates at 16'hFFFF; ERRCNT_CLR=1 forces 0 and takes priority over increment.
REQ-031 Without AHB_DEC_ERRCNT_EN: no counter registers; ERRCNT tied 16'h0; ERRCNT_CLR ignored.

Structure
REQ-032 Shared package ahb_dec_pkg holds HTRANS encodings (IDLE/BUSY/NONSEQ/SEQ), HRESP encodings (OKAY 2'b00, ERROR 2'b01), NUM_SLV=4, DEF_IDX=4.
REQ-033 One sub-module ahb_dec_region_match (address, base, mask -> match) instantiated per region.
REQ-034 Default slave is external; this block only drives its HSEL and consumes its HREADYOUT/HRESP.

Verification
REQ-035 Reset then idle: HRESET=1 one cycle, HSELM=0 -> dsel=default, HREADY=HREADYOUT_DEF, HRDATA=0, ERRCNT=0.
REQ-036 NONSEQ read 32'h2000_0010, slave1 HRDATA=32'hCAFE_F00D, one wait -> HSEL_S=4'b0010 in address phase; HREADY low one cycle, then HRDATA=32'hCAFE_F00D.
REQ-037 NONSEQ to 32'hA000_0000 -> HSEL_DEF=1; default slave returns ERROR two cycles; HRESP=2'b01 both cycles, HREADY 0 then 1; ERRCNT=1 (macro on).
REQ-038 Overlap: MASK1=32'h0, BASE1=32'h0, access 32'h0000_0004 -> HSEL_S=4'b0001 (slave 0 wins).
REQ-039 Back-to-back pipelined NONSEQ slave2 then slave3 with slave2 stalling 3 cycles -> slave3 address held, dsel stays slave2 until HREADY=1, then switches.
REQ-040 ERRCNT preloaded via 65535 default-slave transfers -> holds 16'hFFFF; ERRCNT_CLR with simultaneous hit -> 0; macro off -> ERRCNT constant 0.
